// File: rtl/sel_mux_pkg.sv
// rtl/sel_mux_pkg.sv - shared occupancy encoding and width helper for sel_mux_pipe
package sel_mux_pkg;

    // Occupancy of the two-entry output buffer (main + skid)
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Ceiling log2, never less than 1 so a select port always has a bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sel_mux_comb.sv
// rtl/sel_mux_comb.sv - combinational channel select with out-of-range detection
// Ports:
//   in_data : NUM_IN*WIDTH flattened channels, channel k at [k*WIDTH +: WIDTH]
//   sel     : channel select
//   data    : selected channel (last channel when sel is out of range)
//   err     : sel >= NUM_IN
module sel_mux_comb
    import sel_mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    // A match loop instead of a magnitude compare keeps this free of
    // always-false comparisons when NUM_IN is a power of two.
    always_comb begin
        data = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
        err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                data = in_data[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sel_mux_pipe.sv
// rtl/sel_mux_pipe.sv - registered channel mux with two-entry skid buffer
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_data/in_sel      : flattened channels and select, taken on in_valid && in_ready
//   in_valid/in_ready   : input handshake; in_ready is registered
//   out_data/out_sel    : selected data and the select that produced it
//   out_err             : select was out of range for this entry
//   out_valid/out_ready : output handshake
module sel_mux_pipe
    import sel_mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             in_ready_r;

    logic [WIDTH-1:0] new_data;
    logic             new_err;

    logic [WIDTH-1:0] main_data;
    logic [SEL_W-1:0] main_sel;
    logic             main_err;
    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             skid_err;

    logic             push;
    logic             pop;

    sel_mux_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_comb (
        .in_data (in_data),
        .sel     (in_sel),
        .data    (new_data),
        .err     (new_err)
    );

    assign push = in_valid && in_ready_r;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (push)              state_nxt = ST_ONE;
            ST_ONE: begin
                if (push && !pop)            state_nxt = ST_TWO;
                else if (pop && !push)       state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (pop)               state_nxt = ST_ONE;
            default:                         state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_EMPTY;
            in_ready_r <= 1'b0;
            main_data  <= '0;
            main_sel   <= '0;
            main_err   <= 1'b0;
            skid_data  <= '0;
            skid_sel   <= '0;
            skid_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            // Registered ready: look ahead at next occupancy so the
            // buffer can never be pushed while full.
            in_ready_r <= (state_nxt != ST_TWO);
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        main_data <= new_data;
                        main_sel  <= in_sel;
                        main_err  <= new_err;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_data <= new_data;
                        main_sel  <= in_sel;
                        main_err  <= new_err;
                    end else if (push) begin
                        // Outputs are stalled; park the newer entry in skid
                        skid_data <= new_data;
                        skid_sel  <= in_sel;
                        skid_err  <= new_err;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        main_data <= skid_data;
                        main_sel  <= skid_sel;
                        main_err  <= skid_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = (state == ST_ONE) || (state == ST_TWO);
    assign out_data  = main_data;
    assign out_sel   = main_sel;
    assign out_err   = main_err;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// tb/tb_sel_mux_pipe.sv - self-checking bench for sel_mux_pipe (NUM_IN=4 and NUM_IN=3)
module tb_sel_mux_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_err;
    logic         out_valid;

    logic         in_ready3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;
    logic         out_err3;
    logic         out_valid3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sel_mux_pipe #(.WIDTH(32), .NUM_IN(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    sel_mux_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data[95:0]),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_err   (out_err3),
        .out_valid (out_valid3),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [127:0] data;
        logic [1:0]   sel;
        logic [31:0]  exp4;
        logic [31:0]  exp3;
        logic         err3;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [127:0] pat;

    initial begin
        pat = 128'h44444444_33333333_22222222_11111111;
        vecs[0] = '{pat, 2'd2, 32'h33333333, 32'h33333333, 1'b0};
        vecs[1] = '{pat, 2'd3, 32'h44444444, 32'h33333333, 1'b1};
        vecs[2] = '{128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, 2'd0, 32'h12345678, 32'h12345678, 1'b0};
        vecs[3] = '{128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, 2'd1, 32'hCAFEBABE, 32'hCAFEBABE, 1'b0};
        vecs[4] = '{128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, 2'd3, 32'hDEADBEEF, 32'h0BADF00D, 1'b1};
        vecs[5] = '{128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A, 2'd2, 32'h00000000, 32'h00000000, 1'b0};

        reset     = 1'b1;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_out_err", out_err, 0);
        reset = 1'b0;
        check("rel_in_ready_low", in_ready, 0);
        step();
        check("rel_in_ready_high", in_ready, 1);
        check("rel_in_ready3_high", in_ready3, 1);

        // Single transfers, latency 1, both channel counts
        for (int i = 0; i < 6; i++) begin
            in_data  = vecs[i].data;
            in_sel   = vecs[i].sel;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            in_data  = {4{32'hBAD0BAD0}};
            in_sel   = 2'd0;
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_data", i), out_data, vecs[i].exp4);
            check($sformatf("v%0d_sel", i), out_sel, vecs[i].sel);
            check($sformatf("v%0d_err", i), out_err, 0);
            check($sformatf("v%0d_data3", i), out_data3, vecs[i].exp3);
            check($sformatf("v%0d_sel3", i), out_sel3, vecs[i].sel);
            check($sformatf("v%0d_err3", i), out_err3, vecs[i].err3);
            step();
            check($sformatf("v%0d_idle_valid", i), out_valid, 0);
            check($sformatf("v%0d_idle_valid3", i), out_valid3, 0);
        end

        // Back-pressure: fill main and skid, then drain in order
        in_data   = pat;
        out_ready = 1'b0;
        in_sel    = 2'd0;
        in_valid  = 1'b1;
        step();
        check("bp_one_in_ready", in_ready, 1);
        check("bp_one_data", out_data, 32'h11111111);
        in_sel = 2'd1;
        step();
        check("bp_two_in_ready", in_ready, 0);
        check("bp_two_hold", out_data, 32'h11111111);
        in_sel = 2'd2;
        step();
        check("bp_ignored_push", out_data, 32'h11111111);
        check("bp_ignored_sel", out_sel, 0);
        check("bp_still_full", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_drain_data1", out_data, 32'h22222222);
        check("bp_drain_sel1", out_sel, 1);
        check("bp_drain_valid1", out_valid, 1);
        check("bp_drain_ready", in_ready, 1);
        step();
        check("bp_drain_empty", out_valid, 0);

        // Streaming: one output per cycle, buffer never fills
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_sel = 2'(i % 4);
            step();
            check($sformatf("st%0d_data", i), out_data, 32'h11111111 * (i % 4 + 1));
            check($sformatf("st%0d_valid", i), out_valid, 1);
            check($sformatf("st%0d_ready", i), in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("st_end_valid", out_valid, 0);

        // Reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        step();
        in_sel = 2'd1;
        step();
        in_valid = 1'b0;
        check("rf_full", in_ready, 0);
        #2;
        reset = 1'b1;
        #1;
        check("rf_async_valid", out_valid, 0);
        check("rf_async_ready", in_ready, 0);
        check("rf_async_data", out_data, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("rf_rel_ready", in_ready, 1);
        check("rf_rel_valid", out_valid, 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        step();
        in_valid = 1'b0;
        check("rf_first_data", out_data, 32'h44444444);
        check("rf_first_sel", out_sel, 3);
        check("rf_first_valid", out_valid, 1);
        step();
        check("rf_after_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sel_mux_pipe.md
SEL_MUX_PIPE -- requirements
Module: sel_mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every channel and the output.
REQ-002 SHALL have parameter NUM_IN, default 4, number of input channels; legal range 2..16.
REQ-003 SHALL have derived parameter SEL_W, default clog2(NUM_IN), select width; not overridden by users.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_data  input  NUM_IN*WIDTH  flattened channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port in_sel  input  SEL_W  channel select, sampled with in_data.
REQ-008 SHALL have port in_valid  input  1  producer offers a transfer.
REQ-009 SHALL have port in_ready  output  1  block accepts a transfer this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  selected data, registered.
REQ-011 SHALL have port out_sel  output  SEL_W  in_sel value that accompanied out_data.
REQ-012 SHALL have port out_err  output  1  in_sel was out of range (>= NUM_IN) for this entry.
REQ-013 SHALL have port out_valid  output  1  out_data/out_sel/out_err are valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the current output.

Function
REQ-015 SHALL transfer in when in_valid && in_ready at a rising edge; SHALL transfer out when out_valid && out_ready.
REQ-016 SHALL select channel in_sel; if in_sel >= NUM_IN, SHALL select channel NUM_IN-1 and set out_err=1 for that entry.
REQ-017 SHALL present an accepted entry on the outputs the cycle after acceptance when the buffer was empty (latency 1).
REQ-018 SHALL buffer up to 2 entries (main + skid register); entries leave in acceptance order.
REQ-019 SHALL use occupancy states EMPTY, ONE, TWO: EMPTY->ONE on push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; ONE stays ONE on simultaneous push and pop; TWO->ONE on pop.
REQ-020 SHALL drive in_ready=1 in EMPTY and ONE, 0 in TWO; in_ready SHALL come from a register, not combinationally from out_ready.
REQ-021 SHALL drive out_valid=1 exactly in ONE and TWO.
REQ-022 SHALL hold out_data, out_sel, out_err stable while out_valid=1 and out_ready=0.
REQ-023 On pop in TWO, SHALL move the skid entry to the outputs in the same edge.
REQ-024 SHALL ignore in_data/in_sel when no transfer occurs; SHALL ignore in_valid while in_ready=0.

Reset
REQ-025 On reset assertion, SHALL immediately force state EMPTY, out_valid=0, out_data=0, out_sel=0, out_err=0, in_ready=0, discarding buffered entries, including mid-operation.
REQ-026 SHALL raise in_ready=1 on the first rising edge after reset deasserts.

Structure
REQ-027 SHALL place the occupancy state encoding (EMPTY=0, ONE=1, TWO=2) and a clog2 constant function in shared package sel_mux_pkg.
REQ-028 SHALL implement channel selection and the range check in a combinational sub-module sel_mux_comb (WIDTH, NUM_IN parameters; outputs data and err).

Verification (WIDTH=32, NUM_IN=4 unless stated)
REQ-029 Channels 0x11111111/0x22222222/0x33333333/0x44444444, sel=2, valid 1 cycle, out_ready=1 -> next cycle out_data=0x33333333, out_sel=2, out_err=0, out_valid for 1 cycle.
REQ-030 NUM_IN=3, sel=3 -> out_data = channel 2 value, out_err=1, out_sel=3.
REQ-031 out_ready=0, push sel=0 then sel=1 -> in_ready=0 after second push, out_data holds channel 0; out_ready=1 -> channel 0 then channel 1 on consecutive cycles, in_ready returns 1.
REQ-032 Continuous in_valid=1, out_ready=1, sel cycling 0..3 for 8 cycles -> one output per cycle, order 0,1,2,3,0,1,2,3, state never reaches TWO.
REQ-033 State TWO, assert reset mid-cycle -> out_valid=0 and in_ready=0 immediately; first output after release is the first post-reset push.
